// File: rtl/cache_mem_arbiter_pkg.sv
// Shared cache package: default widths, FSM encoding and requester ids.
package cache_mem_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF = 20;
  localparam int unsigned LINE_W_DEF = 128;

  // Bit positions of each requester inside the 2-bit request/grant vectors
  localparam int unsigned IC_IDX = 0;
  localparam int unsigned DC_IDX = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WB   = 2'd1,
    ST_RD   = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  typedef enum logic {
    ID_IC = 1'b0,
    ID_DC = 1'b1
  } req_id_e;

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Bus bundle between the two cache miss ports, the arbiter and memory.
interface cache_mem_arbiter_if
  import cache_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned LINE_W = LINE_W_DEF
) ();

  // icache miss port
  logic              ic_req_i;
  logic [ADDR_W-1:0] ic_addr_i;
  logic              ic_fill_o;
  logic [LINE_W-1:0] ic_data_o;

  // dcache miss port with victim writeback
  logic              dc_req_i;
  logic [ADDR_W-1:0] dc_addr_i;
  logic              dc_dirty_i;
  logic [ADDR_W-1:0] dc_victim_addr_i;
  logic [LINE_W-1:0] dc_victim_data_i;
  logic              dc_fill_o;
  logic [LINE_W-1:0] dc_data_o;

  // memory port
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [LINE_W-1:0] mem_wdata_o;
  logic              mem_ack_i;
  logic [LINE_W-1:0] mem_rdata_i;

  logic              busy_o;

  // Arbiter side
  modport master (
    input  ic_req_i, ic_addr_i,
    input  dc_req_i, dc_addr_i, dc_dirty_i, dc_victim_addr_i, dc_victim_data_i,
    input  mem_ack_i, mem_rdata_i,
    output ic_fill_o, ic_data_o, dc_fill_o, dc_data_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, busy_o
  );

  // Caches and memory side
  modport slave (
    output ic_req_i, ic_addr_i,
    output dc_req_i, dc_addr_i, dc_dirty_i, dc_victim_addr_i, dc_victim_data_i,
    output mem_ack_i, mem_rdata_i,
    input  ic_fill_o, ic_data_o, dc_fill_o, dc_data_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, busy_o
  );

endinterface

// File: rtl/cache_mem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; remembers the last winner between grants.
module rr_arb2
  import cache_mem_arbiter_pkg::*;
(
  input  logic       clk_i,
  input  logic       rsn_i,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  req_id_e last_q;

  // On a collision the requester that did not win last time goes first
  always_comb begin
    grant = 2'b00;
    if (req[IC_IDX] && req[DC_IDX]) begin
      if (last_q == ID_IC) begin
        grant[DC_IDX] = 1'b1;
      end else begin
        grant[IC_IDX] = 1'b1;
      end
    end else begin
      grant = req;
    end
  end

  // Record the winner whenever a grant is actually taken; icache after reset so dcache wins first
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      last_q <= ID_IC;
    end else if (accept && (|grant)) begin
      last_q <= grant[DC_IDX] ? ID_DC : ID_IC;
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one memory port between icache and dcache refills, with dcache victim writeback.
module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned LINE_W = LINE_W_DEF
) (
  input  logic clk_i,
  input  logic rsn_i,
  cache_mem_arbiter_if.master bus
);

  state_e            state_q, state_d;
  req_id_e           id_q, id_d;
  logic [ADDR_W-1:0] miss_addr_q, miss_addr_d;

  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              ic_fill_q, ic_fill_d;
  logic              dc_fill_q, dc_fill_d;
  logic [LINE_W-1:0] ic_data_q, ic_data_d;
  logic [LINE_W-1:0] dc_data_q, dc_data_d;
  logic              busy_q, busy_d;

  logic [1:0]        req_vec;
  logic [1:0]        grant;
  logic              idle;

  assign req_vec[IC_IDX] = bus.ic_req_i;
  assign req_vec[DC_IDX] = bus.dc_req_i;
  assign idle            = (state_q == ST_IDLE);

  rr_arb2 u_rr_arb2 (
    .clk_i  (clk_i),
    .rsn_i  (rsn_i),
    .req    (req_vec),
    .accept (idle),
    .grant  (grant)
  );

  // Next state plus next value of every registered output
  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    miss_addr_d = miss_addr_q;
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ic_fill_d   = 1'b0;
    dc_fill_d   = 1'b0;
    ic_data_d   = ic_data_q;
    dc_data_d   = dc_data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (grant[DC_IDX]) begin
          id_d        = ID_DC;
          miss_addr_d = bus.dc_addr_i;
          mem_req_d   = 1'b1;
          if (bus.dc_dirty_i) begin
            // Victim goes out first; its address/data are held in the memory-port registers
            state_d     = ST_WB;
            mem_we_d    = 1'b1;
            mem_addr_d  = bus.dc_victim_addr_i;
            mem_wdata_d = bus.dc_victim_data_i;
          end else begin
            state_d    = ST_RD;
            mem_addr_d = bus.dc_addr_i;
          end
        end else if (grant[IC_IDX]) begin
          id_d        = ID_IC;
          miss_addr_d = bus.ic_addr_i;
          state_d     = ST_RD;
          mem_req_d   = 1'b1;
          mem_addr_d  = bus.ic_addr_i;
        end
      end

      ST_WB: begin
        mem_req_d = 1'b1;
        mem_we_d  = 1'b1;
        if (bus.mem_ack_i) begin
          state_d    = ST_RD;
          mem_we_d   = 1'b0;
          mem_addr_d = miss_addr_q;
        end
      end

      ST_RD: begin
        mem_req_d = 1'b1;
        if (bus.mem_ack_i) begin
          state_d   = ST_RESP;
          mem_req_d = 1'b0;
          if (id_q == ID_DC) begin
            dc_data_d = bus.mem_rdata_i;
            dc_fill_d = 1'b1;
          end else begin
            ic_data_d = bus.mem_rdata_i;
            ic_fill_d = 1'b1;
          end
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State, latched request fields and registered outputs
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_q     <= ST_IDLE;
      id_q        <= ID_IC;
      miss_addr_q <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ic_fill_q   <= 1'b0;
      dc_fill_q   <= 1'b0;
      ic_data_q   <= '0;
      dc_data_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      miss_addr_q <= miss_addr_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ic_fill_q   <= ic_fill_d;
      dc_fill_q   <= dc_fill_d;
      ic_data_q   <= ic_data_d;
      dc_data_q   <= dc_data_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.mem_req_o   = mem_req_q;
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_wdata_o = mem_wdata_q;
  assign bus.ic_fill_o   = ic_fill_q;
  assign bus.ic_data_o   = ic_data_q;
  assign bus.dc_fill_o   = dc_fill_q;
  assign bus.dc_data_o   = dc_data_q;
  assign bus.busy_o      = busy_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed + randomized bench for cache_mem_arbiter with a transaction-level reference model.
module tb_cache_mem_arbiter;
  import cache_mem_arbiter_pkg::*;

  localparam int unsigned AW = 20;
  localparam int unsigned LW = 128;

  typedef struct {
    bit          we;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
    logic [LW-1:0] rdata;
    bit          stable;
  } txn_t;

  typedef struct {
    bit          dc;
    logic [LW-1:0] data;
  } fill_t;

  logic clk = 1'b0;
  logic rsn;
  int   checks = 0;
  int   failures = 0;

  cache_mem_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();

  cache_mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk_i (clk),
    .rsn_i (rsn),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Memory model controls (written only by the stimulus block)
  int            ack_delay = 0;
  bit            rand_delay = 1'b0;
  bit            fixed_en = 1'b0;
  logic [LW-1:0] fixed_data = '0;
  bit            spur_ack = 1'b0;

  // Memory model state (written only by the responder)
  txn_t log_q[$];
  bit   in_txn = 1'b0;
  int   cnt = 0;
  int   cur_delay = 0;
  txn_t snap;

  // Memory responder: acks each request after a chosen delay and logs what it saw
  always @(negedge clk) begin
    bus.mem_ack_i = 1'b0;
    if (spur_ack) begin
      bus.mem_ack_i   = 1'b1;
      bus.mem_rdata_i = {4{32'hDEAD_BEEF}};
    end else if (rsn === 1'b1 && bus.mem_req_o === 1'b1) begin
      if (!in_txn) begin
        in_txn      = 1'b1;
        cnt         = 0;
        cur_delay   = rand_delay ? int'($urandom_range(0, 3)) : ack_delay;
        snap.we     = bus.mem_we_o;
        snap.addr   = bus.mem_addr_o;
        snap.wdata  = bus.mem_wdata_o;
        snap.rdata  = '0;
        snap.stable = 1'b1;
      end else if (bus.mem_we_o !== snap.we || bus.mem_addr_o !== snap.addr ||
                   bus.mem_wdata_o !== snap.wdata) begin
        snap.stable = 1'b0;
      end
      if (cnt >= cur_delay) begin
        snap.rdata      = fixed_en ? fixed_data : {$urandom, $urandom, $urandom, $urandom};
        bus.mem_ack_i   = 1'b1;
        bus.mem_rdata_i = snap.rdata;
        log_q.push_back(snap);
        in_txn = 1'b0;
      end else begin
        cnt++;
      end
    end else begin
      in_txn = 1'b0;
    end
  end

  fill_t         fills_q[$];
  bit            last_dc;
  logic [LW-1:0] ic_data_m;
  logic [LW-1:0] dc_data_m;

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: sample just after the edge, behave like the caches on a fill
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.ic_fill_o === 1'b1 || bus.dc_fill_o === 1'b1) begin
      chk_int("mem_req_low_in_resp", int'(bus.mem_req_o), 0);
    end
    if (bus.ic_fill_o === 1'b1) begin
      fills_q.push_back('{1'b0, bus.ic_data_o});
      bus.ic_req_i = 1'b0;
    end
    if (bus.dc_fill_o === 1'b1) begin
      fills_q.push_back('{1'b1, bus.dc_data_o});
      bus.dc_req_i = 1'b0;
    end
  endtask

  task automatic model_reset();
    last_dc   = 1'b0;
    ic_data_m = '0;
    dc_data_m = '0;
  endtask

  task automatic wait_idle(input string tag);
    int budget = 200;
    while ((bus.ic_req_i || bus.dc_req_i || bus.busy_o) && budget > 0) begin
      tick();
      budget--;
    end
    chk_int(tag, int'(budget > 0), 1);
  endtask

  // Issue requests together, then compare memory traffic and fills with the model
  task automatic run_round(input bit do_ic, input bit do_dc, input bit dirty,
                           input logic [AW-1:0] ia, input logic [AW-1:0] da,
                           input logic [AW-1:0] va, input logic [LW-1:0] vd);
    bit            order[$];
    int            li = 0;
    int            fi = 0;
    logic [LW-1:0] exp_rd;
    log_q.delete();
    fills_q.delete();
    bus.ic_addr_i        = ia;
    bus.dc_addr_i        = da;
    bus.dc_dirty_i       = dirty;
    bus.dc_victim_addr_i = va;
    bus.dc_victim_data_i = vd;
    bus.ic_req_i         = do_ic;
    bus.dc_req_i         = do_dc;
    if (do_ic && do_dc) begin
      if (last_dc) order = '{1'b0, 1'b1};
      else         order = '{1'b1, 1'b0};
    end else if (do_dc) begin
      order = '{1'b1};
    end else if (do_ic) begin
      order = '{1'b0};
    end
    wait_idle("round_timeout");
    for (int k = 0; k < order.size(); k++) begin
      if (order[k] && dirty) begin
        if (li < log_q.size()) begin
          chk_int("wb_we", int'(log_q[li].we), 1);
          chk("wb_addr", LW'(log_q[li].addr), LW'(va));
          chk("wb_data", log_q[li].wdata, vd);
          chk_int("wb_stable", int'(log_q[li].stable), 1);
        end
        li++;
      end
      exp_rd = '0;
      if (li < log_q.size()) begin
        chk_int("rd_we", int'(log_q[li].we), 0);
        chk("rd_addr", LW'(log_q[li].addr), LW'(order[k] ? da : ia));
        chk_int("rd_stable", int'(log_q[li].stable), 1);
        exp_rd = log_q[li].rdata;
      end
      li++;
      if (fi < fills_q.size()) begin
        chk_int("fill_owner", int'(fills_q[fi].dc), int'(order[k]));
        chk("fill_data", fills_q[fi].data, exp_rd);
      end
      fi++;
      if (order[k]) dc_data_m = exp_rd;
      else          ic_data_m = exp_rd;
      last_dc = order[k];
    end
    chk_int("txn_count", log_q.size(), li);
    chk_int("fill_count", fills_q.size(), fi);
    chk("ic_data_hold", bus.ic_data_o, ic_data_m);
    chk("dc_data_hold", bus.dc_data_o, dc_data_m);
  endtask

  // Cycles from raising a request (counted as cycle 1) until its fill is seen
  task automatic measure_latency(input bit is_dc, output int cyc);
    fills_q.delete();
    if (is_dc) bus.dc_req_i = 1'b1;
    else       bus.ic_req_i = 1'b1;
    cyc = 1;
    while (fills_q.size() == 0 && cyc < 40) begin
      tick();
      cyc++;
    end
    wait_idle("latency_idle");
    last_dc = is_dc;
    if (is_dc) dc_data_m = fixed_data;
    else       ic_data_m = fixed_data;
  endtask

  initial begin
    int cyc;
    logic [2:0] kind;

    rsn                  = 1'b0;
    bus.ic_req_i         = 1'b0;
    bus.ic_addr_i        = '0;
    bus.dc_req_i         = 1'b0;
    bus.dc_addr_i        = '0;
    bus.dc_dirty_i       = 1'b0;
    bus.dc_victim_addr_i = '0;
    bus.dc_victim_data_i = '0;
    model_reset();

    // Reset values
    @(posedge clk);
    #1;
    chk_int("rst_busy", int'(bus.busy_o), 0);
    chk_int("rst_mem_req", int'(bus.mem_req_o), 0);
    chk_int("rst_mem_we", int'(bus.mem_we_o), 0);
    chk("rst_mem_addr", LW'(bus.mem_addr_o), '0);
    chk("rst_mem_wdata", bus.mem_wdata_o, '0);
    chk_int("rst_ic_fill", int'(bus.ic_fill_o), 0);
    chk_int("rst_dc_fill", int'(bus.dc_fill_o), 0);
    chk("rst_ic_data", bus.ic_data_o, '0);
    chk("rst_dc_data", bus.dc_data_o, '0);
    rsn = 1'b1;
    tick();

    // Lone icache miss, ack two cycles after the request
    ack_delay  = 2;
    fixed_en   = 1'b1;
    fixed_data = {16{8'hA5}};
    run_round(1'b1, 1'b0, 1'b0, 20'h00123, 20'h0, 20'h0, '0);
    chk("ic_a5_data", bus.ic_data_o, {16{8'hA5}});
    fills_q.delete();
    repeat (4) tick();
    chk_int("no_extra_fill", fills_q.size(), 0);

    // Dirty dcache miss: writeback of the victim, then the refill read
    fixed_data = {4{32'h0BAD_F00D}};
    run_round(1'b0, 1'b1, 1'b1, 20'h0, 20'h00080, 20'h00040, {32{4'h1}});

    // Minimum latency with ack in the first request cycle
    ack_delay      = 0;
    fixed_data     = {4{32'h1234_5678}};
    bus.ic_addr_i  = 20'h00ABC;
    measure_latency(1'b0, cyc);
    chk_int("clean_latency", cyc, 3);
    chk("latency_ic_data", bus.ic_data_o, ic_data_m);
    bus.dc_dirty_i = 1'b1;
    measure_latency(1'b1, cyc);
    chk_int("dirty_latency_longer", int'(cyc >= 4), 1);

    // Fresh reset, then colliding requests alternate starting with dcache
    rsn = 1'b0;
    #2;
    rsn = 1'b1;
    model_reset();
    chk("rst2_ic_data", bus.ic_data_o, '0);
    tick();
    rand_delay = 1'b1;
    fixed_en   = 1'b0;
    for (int r = 0; r < 4; r++) begin
      run_round(1'b1, 1'b1, 1'($urandom_range(0, 1)), AW'($urandom), AW'($urandom),
                AW'($urandom), {$urandom, $urandom, $urandom, $urandom});
    end

    // Reset in the middle of a read, then a stray ack while idle
    rand_delay    = 1'b0;
    ack_delay     = 6;
    fills_q.delete();
    bus.ic_addr_i = 20'h00777;
    bus.ic_req_i  = 1'b1;
    tick();
    tick();
    chk_int("rd_in_progress", int'(bus.mem_req_o), 1);
    #2;
    rsn = 1'b0;
    #1;
    chk_int("abort_busy", int'(bus.busy_o), 0);
    chk_int("abort_mem_req", int'(bus.mem_req_o), 0);
    chk("abort_mem_addr", LW'(bus.mem_addr_o), '0);
    chk("abort_ic_data", bus.ic_data_o, '0);
    chk("abort_dc_data", bus.dc_data_o, '0);
    bus.ic_req_i = 1'b0;
    bus.dc_req_i = 1'b0;
    tick();
    rsn = 1'b1;
    model_reset();
    spur_ack = 1'b1;
    tick();
    spur_ack = 1'b0;
    repeat (3) tick();
    chk_int("spurious_no_fill", fills_q.size(), 0);
    chk_int("spurious_idle", int'(bus.busy_o), 0);
    chk("spurious_ic_data", bus.ic_data_o, '0);

    // Randomized mixes of lone and colliding requests
    rand_delay = 1'b1;
    for (int r = 0; r < 40; r++) begin
      kind = 3'($urandom_range(1, 3));
      run_round(kind[0], kind[1], 1'($urandom_range(0, 1)), AW'($urandom), AW'($urandom),
                AW'($urandom), {$urandom, $urandom, $urandom, $urandom});
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cache_mem_arbiter.md
CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 20, meaning line-address width.
REQ-002 The block SHALL have parameter LINE_W, default 128, meaning cache-line width in bits.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rsn_i  input  1  reset, asynchronous, active-low.
REQ-005 ic_req_i  input  1  icache miss request, held until ic_fill_o observed.
REQ-006 ic_addr_i  input  ADDR_W  icache miss line address.
REQ-007 ic_fill_o  output  1  one-cycle pulse: ic_data_o valid.
REQ-008 ic_data_o  output  LINE_W  icache refill line.
REQ-009 dc_req_i  input  1  dcache miss request, held until dc_fill_o observed.
REQ-010 dc_addr_i  input  ADDR_W  dcache miss line address.
REQ-011 dc_dirty_i  input  1  victim (LRU way) is dirty; writeback needed.
REQ-012 dc_victim_addr_i  input  ADDR_W  victim line address.
REQ-013 dc_victim_data_i  input  LINE_W  victim line data.
REQ-014 dc_fill_o  output  1  one-cycle pulse: dc_data_o valid.
REQ-015 dc_data_o  output  LINE_W  dcache refill line.
REQ-016 mem_req_o  output  1  memory transaction request.
REQ-017 mem_we_o  output  1  1 = write (writeback), 0 = read (refill).
REQ-018 mem_addr_o  output  ADDR_W  memory line address.
REQ-019 mem_wdata_o  output  LINE_W  writeback data.
REQ-020 mem_ack_i  input  1  one-cycle completion pulse from memory.
REQ-021 mem_rdata_i  input  LINE_W  read data, valid with mem_ack_i on a read.
REQ-022 busy_o  output  1  high whenever state is not IDLE.

Function
REQ-023 All outputs SHALL be registered.
REQ-024 FSM states SHALL be IDLE, WB, RD, RESP.
REQ-025 IDLE: with no request, stay; any pending request SHALL be granted, FSM leaving IDLE at the next edge.
REQ-026 Both requests in the same IDLE cycle: grant the requester not granted last (round-robin); after reset dcache wins first.
REQ-027 At grant: latch requester id, miss address, and for dcache dirty flag, victim address and victim data; later input changes SHALL be ignored until IDLE.
REQ-028 Dcache grant with dc_dirty_i=1 -> WB; otherwise (or icache grant) -> RD.
REQ-029 WB: mem_req_o=1, mem_we_o=1, mem_addr_o=victim address, mem_wdata_o=victim data; on mem_ack_i -> RD.
REQ-030 RD: mem_req_o=1, mem_we_o=0, mem_addr_o=miss address; on mem_ack_i capture mem_rdata_i into granted requester's data output -> RESP.
REQ-031 mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o SHALL stay stable from assertion until the ack edge; mem_req_o SHALL drop for at least the RESP cycle.
REQ-032 mem_ack_i in first request cycle SHALL be accepted; mem_ack_i while mem_req_o=0 SHALL be ignored.
REQ-033 RESP: pulse granted fill output for exactly one cycle, data stable; -> IDLE.
REQ-034 Requester deasserts req on the edge where it sees fill=1; IDLE therefore never re-grants a completed request.
REQ-035 Minimum latency request-to-fill: clean miss, ack in first cycle = 3 cycles; dirty adds >=1 cycle.
REQ-036 ic_data_o/dc_data_o SHALL hold last refill value between fills.

Reset
REQ-037 rsn_i low SHALL asynchronously force IDLE, last-grant = icache, all outputs and latched fields to 0, including mid-transaction; the aborted transaction is not resumed.

Structure
REQ-038 State encoding, ADDR_W/LINE_W defaults and requester-id constants SHALL live in the shared cache package.
REQ-039 A 2-input round-robin sub-module rr_arb2 (req[1:0], last-grant state, grant[1:0]) SHALL be used.

Verification
REQ-040 Lone ic_req_i, addr 0x00123, ack 2 cycles after mem_req_o with rdata 0xA5..A5 -> one read at 0x00123, ic_fill_o pulse once, ic_data_o=0xA5..A5.
REQ-041 dc_req_i dirty, victim 0x00040/0x1111..11, miss 0x00080 -> write at 0x00040 with that data, then read at 0x00080, dc_fill_o once.
REQ-042 ic_req_i and dc_req_i same cycle after reset -> dcache served first, then icache; repeated collisions alternate.
REQ-043 Ack in first request cycle, clean miss -> fill pulse exactly 3 cycles after request.
REQ-044 rsn_i low during RD -> outputs 0 immediately, busy_o=0; spurious mem_ack_i while idle causes no fill.
